// File: rtl/sdram_host_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sdram_host_arbiter
//
// Lets two independent requesters (for example a CPU and a video/DMA engine)
// share the single-word host port of an SDRAM controller. Only one transaction
// is in flight at a time. The arbiter accepts a request and registers its
// fields, then issues one rd_enable or wr_enable strobe. It follows the
// controller's busy signal until the transaction completes, and returns done
// (and read data) to the port that owns the transaction. If the controller
// never raises busy, the transaction is aborted with done+err.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req*/wr*/addr*/wdata*   per-port request; the request level is held, with
//                           its fields stable, until gnt
//   gnt*                    one-cycle pulse: request accepted, fields latched
//   done*/err*              one-cycle completion pulse; err marks a timeout
//   rdata*                  read data; valid from done, held until the next
//                           read completes on that port
//   haddr/data_input        address and write data to the controller
//   data_output/busy        read data and busy from the controller
//   rd_enable/wr_enable     command strobes to the controller
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request while the controller is not busy
// ISSUE | single cycle: gnt and one command strobe are high
// WBUSY | waiting for the controller to raise busy; timeout runs here
// WDONE | controller busy; completes on the first sample of busy low
// -----------------------------------------------------------------------------
module sdram_host_arbiter #(
  parameter int HADDR_WIDTH  = 24,
  parameter int DATA_WIDTH   = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   req0,
  input  logic                   wr0,
  input  logic [HADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]  wdata0,
  output logic                   gnt0,
  output logic                   done0,
  output logic                   err0,
  output logic [DATA_WIDTH-1:0]  rdata0,

  input  logic                   req1,
  input  logic                   wr1,
  input  logic [HADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]  wdata1,
  output logic                   gnt1,
  output logic                   done1,
  output logic                   err1,
  output logic [DATA_WIDTH-1:0]  rdata1,

  output logic [HADDR_WIDTH-1:0] haddr,
  output logic [DATA_WIDTH-1:0]  data_input,
  input  logic [DATA_WIDTH-1:0]  data_output,
  input  logic                   busy,
  output logic                   rd_enable,
  output logic                   wr_enable
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WBUSY = 2'd2;
  localparam logic [1:0] S_WDONE = 2'd3;

  // The timeout is a down-counter. It is loaded in ISSUE, and the terminal
  // count is 0. With a load of BUSY_TIMEOUT-1, done/err land BUSY_TIMEOUT+1
  // cycles after ISSUE.
  localparam logic [7:0] TMO_LOAD = 8'(BUSY_TIMEOUT - 1);

  logic [1:0]  state;
  logic        owner;      // port that owns the in-flight transaction
  logic        op_wr;      // 1 = write in flight
  logic        last_gnt;   // port that most recently completed
  logic [7:0]  tmo_cnt;

  logic                   any_req;
  logic                   win;
  logic                   win_wr;
  logic [HADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]  win_wdata;

  // Round-robin choice: a sole requester wins. On a tie, the port that did
  // not complete last wins.
  always_comb begin
    any_req   = req0 | req1;
    win       = 1'b0;
    if (req0 && req1) begin
      win = ~last_gnt;
    end else if (req1) begin
      win = 1'b1;
    end
    win_wr    = win ? wr1    : wr0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      op_wr      <= 1'b0;
      last_gnt   <= 1'b1;
      tmo_cnt    <= 8'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rd_enable  <= 1'b0;
      wr_enable  <= 1'b0;
      haddr      <= '0;
      data_input <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      // All strobes are single-cycle. Each one is cleared here unless it is
      // re-asserted below.
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rd_enable <= 1'b0;
      wr_enable <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!busy && any_req) begin
            owner      <= win;
            op_wr      <= win_wr;
            haddr      <= win_addr;
            data_input <= win_wdata;
            gnt0       <= ~win;
            gnt1       <= win;
            rd_enable  <= ~win_wr;
            wr_enable  <= win_wr;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          tmo_cnt <= TMO_LOAD;
          state   <= S_WBUSY;
        end

        S_WBUSY: begin
          if (busy) begin
            state <= S_WDONE;
          end else if (tmo_cnt == 8'd0) begin
            done0    <= ~owner;
            done1    <= owner;
            err0     <= ~owner;
            err1     <= owner;
            last_gnt <= owner;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end

        S_WDONE: begin
          if (!busy) begin
            done0    <= ~owner;
            done1    <= owner;
            last_gnt <= owner;
            if (!op_wr) begin
              if (owner) begin
                rdata1 <= data_output;
              end else begin
                rdata0 <= data_output;
              end
            end
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
`timescale 1ns/1ps
// Scoreboarded bench for sdram_host_arbiter. Directed stimulus pushes the
// expected grant/done events. A monitor on the falling edge pops and checks
// them, and also checks the strobe invariants every cycle. A small controller
// model answers each command strobe with a programmable busy pulse.
module tb_sdram_host_arbiter;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          clk, rst_n;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, done0, err0, gnt1, done1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] haddr;
  logic [DW-1:0] data_input, data_output;
  logic          busy, rd_enable, wr_enable;

  logic          model_busy, ext_busy, no_busy, m_abort, m_pend;
  int            busy_len, m_cnt;
  logic [DW-1:0] rd_value;

  assign busy = model_busy | ext_busy;

  sdram_host_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
    .haddr(haddr), .data_input(data_input), .data_output(data_output),
    .busy(busy), .rd_enable(rd_enable), .wr_enable(wr_enable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    bit            is_done;
    bit            port;
    bit            err;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    int            ref_cyc;
    int            lat;
  } ev_t;

  ev_t           sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            last_gnt_cyc = 0;
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push_gnt(bit port, bit wr, logic [AW-1:0] a, logic [DW-1:0] d,
                          int ref_c, int lat);
    ev_t e;
    e = '{is_done: 1'b0, port: port, err: 1'b0, wr: wr, addr: a, wdata: d,
          rd0: '0, rd1: '0, ref_cyc: ref_c, lat: lat};
    sb.push_back(e);
  endtask

  // The expected read data comes from rd_value, which is what the controller
  // model presents when busy falls.
  task automatic push_done(bit port, bit err, bit wr, int lat);
    ev_t e;
    if (!err && !wr) begin
      if (port) exp_rd1 = rd_value;
      else      exp_rd0 = rd_value;
    end
    e = '{is_done: 1'b1, port: port, err: err, wr: wr, addr: '0, wdata: '0,
          rd0: exp_rd0, rd1: exp_rd1, ref_cyc: -1, lat: lat};
    sb.push_back(e);
  endtask

  // Controller model: busy rises one cycle after the strobe and stays high
  // for busy_len cycles. Read data appears as busy falls.
  initial begin
    model_busy  = 1'b0;
    data_output = '0;
    m_pend      = 1'b0;
    m_cnt       = 0;
    forever begin
      @(negedge clk);
      if (m_abort) begin
        model_busy = 1'b0;
        m_pend     = 1'b0;
        m_cnt      = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          model_busy  = 1'b0;
          data_output = rd_value;
        end
      end else if (m_pend) begin
        m_pend      = 1'b0;
        model_busy  = 1'b1;
        data_output = 16'hDEAD;
        m_cnt       = busy_len;
      end
      if ((rd_enable || wr_enable) && !no_busy && !m_abort) m_pend = 1'b1;
    end
  end

  // Monitor
  logic [AW-1:0] prev_haddr;
  logic [DW-1:0] prev_din;
  logic          prev_rst = 1'b0;
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (rst_n) begin
      if (rd_enable && wr_enable) begin
        miscompares++;
        $display("FAIL both_enables: rd_enable=1 wr_enable=1 required one-hot");
      end
      if ((rd_enable || wr_enable) && !(gnt0 || gnt1)) begin
        miscompares++;
        $display("FAIL enable_outside_issue: enable high with no gnt");
      end
      if ((err0 && !done0) || (err1 && !done1)) begin
        miscompares++;
        $display("FAIL err_without_done: err=%b%b done=%b%b", err1, err0, done1, done0);
      end
      if (prev_rst && !(gnt0 || gnt1) && (haddr !== prev_haddr || data_input !== prev_din)) begin
        miscompares++;
        $display("FAIL hold_fields: haddr/data_input changed to 0x%0h/0x%0h without grant",
                 haddr, data_input);
      end
      if (gnt0 || gnt1 || done0 || done1) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: gnt=%b%b done=%b%b required none",
                   gnt1, gnt0, done1, done0);
        end else begin
          e = sb.pop_front();
          if (!e.is_done) begin
            chk("gnt_port", 32'({gnt1, gnt0, done1, done0}), e.port ? 32'h8 : 32'h4);
            chk("rd_enable", 32'(rd_enable), 32'(!e.wr));
            chk("wr_enable", 32'(wr_enable), 32'(e.wr));
            chk("haddr", 32'(haddr), 32'(e.addr));
            chk("data_input", 32'(data_input), 32'(e.wdata));
            if (e.ref_cyc >= 0) chk("gnt_latency", 32'(cyc - e.ref_cyc), 32'(e.lat));
            last_gnt_cyc = cyc;
          end else begin
            chk("done_port", 32'({gnt1, gnt0, done1, done0}), e.port ? 32'h2 : 32'h1);
            chk("err", 32'({err1, err0}), e.err ? (e.port ? 32'h2 : 32'h1) : 32'h0);
            chk("rdata0", 32'(rdata0), 32'(e.rd0));
            chk("rdata1", 32'(rdata1), 32'(e.rd1));
            if (e.lat > 0) chk("done_latency", 32'(cyc - last_gnt_cyc), 32'(e.lat));
          end
        end
      end
    end
    prev_haddr = haddr;
    prev_din   = data_input;
    prev_rst   = rst_n;
  end

  task automatic wait_gnt(bit port);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((!port && gnt0) || (port && gnt1)) return;
    end
    miscompares++;
    $display("FAIL wait_gnt%0d: no grant within 100 cycles", port);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected events still pending", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_txn(bit port, bit wr, logic [AW-1:0] a, logic [DW-1:0] d,
                        int blen, bit tmo);
    busy_len = blen;
    no_busy  = tmo;
    push_gnt(port, wr, a, d, -1, 0);
    push_done(port, tmo, wr, tmo ? TMO + 1 : blen + 2);
    if (port) begin
      wr1 = wr; addr1 = a; wdata1 = d; req1 = 1'b1;
    end else begin
      wr0 = wr; addr0 = a; wdata0 = d; req0 = 1'b1;
    end
    wait_gnt(port);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
    drain();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_strobes"}, 32'({gnt0, gnt1, done0, done1, err0, err1, rd_enable, wr_enable}), 32'h0);
    chk({tag, "_haddr"}, 32'(haddr), 32'h0);
    chk({tag, "_data_input"}, 32'(data_input), 32'h0);
    chk({tag, "_rdata0"}, 32'(rdata0), 32'h0);
    chk({tag, "_rdata1"}, 32'(rdata1), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    ext_busy = 1'b0; no_busy = 1'b0; m_abort = 1'b0;
    busy_len = 4; rd_value = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read on port 0
    rd_value = 16'hBEEF;
    do_txn(1'b0, 1'b0, 24'h000123, 16'h0000, 4, 1'b0);

    // Single write on port 1; data_output changes, but rdata must not
    rd_value = 16'h1111;
    do_txn(1'b1, 1'b1, 24'hABCDEF, 16'h5A5A, 3, 1'b0);

    // Contention: both ports held for four transactions
    rd_value = 16'hC0DE;
    busy_len = 2;
    no_busy  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_gnt(1'b0, 1'b0, 24'h000010, 16'h0A0A, -1, 0);
      push_done(1'b0, 1'b0, 1'b0, 4);
      push_gnt(1'b1, 1'b1, 24'h000020, 16'h1234, -1, 0);
      push_done(1'b1, 1'b0, 1'b1, 4);
    end
    wr0 = 1'b0; addr0 = 24'h000010; wdata0 = 16'h0A0A; req0 = 1'b1;
    wr1 = 1'b1; addr1 = 24'h000020; wdata1 = 16'h1234; req1 = 1'b1;
    n = 0;
    for (int t = 0; t < 200 && n < 4; t++) begin
      @(negedge clk);
      if (gnt0 || gnt1) n++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    if (n != 4) begin
      miscompares++;
      $display("FAIL contention_grants: got %0d grants required 4", n);
    end
    drain();

    // Timeout: controller never raises busy
    do_txn(1'b0, 1'b0, 24'h000456, 16'h0000, 0, 1'b1);
    rd_value = 16'h7777;
    do_txn(1'b1, 1'b0, 24'h000789, 16'h0000, 2, 1'b0);

    // Busy held high externally while port 1 requests
    busy_len = 2;
    no_busy  = 1'b0;
    ext_busy = 1'b1;
    wr1 = 1'b1; addr1 = 24'h000ABC; wdata1 = 16'h4321; req1 = 1'b1;
    repeat (6) @(negedge clk);
    push_gnt(1'b1, 1'b1, 24'h000ABC, 16'h4321, cyc, 1);
    push_done(1'b1, 1'b0, 1'b1, 4);
    ext_busy = 1'b0;
    wait_gnt(1'b1);
    req1 = 1'b0;
    drain();

    // Reset while in WAIT_DONE
    rd_value = 16'h9999;
    busy_len = 10;
    push_gnt(1'b0, 1'b0, 24'h000DEF, 16'h0000, -1, 0);
    wr0 = 1'b0; addr0 = 24'h000DEF; wdata0 = 16'h0000; req0 = 1'b1;
    wait_gnt(1'b0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n   = 1'b0;
    m_abort = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_rd0 = '0;
    exp_rd1 = '0;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    m_abort = 1'b0;
    @(negedge clk);

    // A tie after reset goes to port 0 first, then to port 1
    rd_value = 16'h2468;
    busy_len = 2;
    push_gnt(1'b0, 1'b0, 24'h000111, 16'h0000, -1, 0);
    push_done(1'b0, 1'b0, 1'b0, 4);
    push_gnt(1'b1, 1'b1, 24'h000222, 16'h1357, -1, 0);
    push_done(1'b1, 1'b0, 1'b1, 4);
    wr0 = 1'b0; addr0 = 24'h000111; wdata0 = 16'h0000; req0 = 1'b1;
    wr1 = 1'b1; addr1 = 24'h000222; wdata1 = 16'h1357; req1 = 1'b1;
    wait_gnt(1'b0);
    req0 = 1'b0;
    wait_gnt(1'b1);
    req1 = 1'b0;
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
